turn_controller: RTL and testbench

Sequencing controller for the two-player game. It owns the turn timer: it arms, enables and clears the timer at each turn boundary. It arbitrates between a player's manual move and the timeout-driven automatic move, hands the single board-update port to exactly one of them, and tracks the current player, move count and end of game. It sits between the input/debounce logic, the turn timer, the board/win-check logic and the display driver.

---
 rtl/game_pkg.sv | 25 ++
 rtl/turn_controller.sv | 134 +++++++++++++
 tb/tb_turn_controller.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared types and helpers for the two-player game: controller state encoding,
// winner codes and the saturating seconds subtraction used by the display path.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_TURN   = 3'd2,
        ST_GRANT  = 3'd3,
        ST_WAIT_M = 3'd4,
        ST_AUTO   = 3'd5,
        ST_CHECK  = 3'd6,
        ST_OVER   = 3'd7
    } ctrl_state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P0   = 2'b01;
    localparam logic [1:0] WIN_P1   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    function automatic logic [3:0] sat_sub4(input logic [3:0] a, input logic [3:0] b);
        return (a > b) ? (a - b) : 4'd0;
    endfunction

endpackage

// File: rtl/turn_controller.sv
// Turn sequencing for the two-player game: drives the turn timer, arbitrates
// manual versus timeout moves onto the single board port, and tracks the score state.
module turn_controller
    import game_pkg::*;
#(
    parameter int TURN_SECONDS = 10,
    parameter int MAX_MOVES    = 42
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             move_req,
    input  logic                             timer_timeout,
    input  logic [3:0]                       timer_seconds,
    input  logic                             board_done,
    input  logic                             board_ok,
    input  logic                             board_win,
    output logic                             timer_enable,
    output logic                             timer_reset,
    output logic                             move_grant,
    output logic                             auto_req,
    output logic                             current_player,
    output logic [$clog2(MAX_MOVES+1)-1:0]   turn_count,
    output logic [3:0]                       seconds_left,
    output logic                             game_over,
    output logic [1:0]                       winner
);

    localparam int CW = $clog2(MAX_MOVES + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(MAX_MOVES - 1);
    localparam logic [3:0]    TURN_SEC4  = 4'(TURN_SECONDS);

    ctrl_state_t state;
    logic        auto_move;
    logic        res_ok;
    logic        res_win;

    assign seconds_left = sat_sub4(TURN_SEC4, timer_seconds);

    // Outputs are assigned on the transition into each state so they are
    // valid in the same cycle the state register shows that state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= ST_IDLE;
            auto_move      <= 1'b0;
            res_ok         <= 1'b0;
            res_win        <= 1'b0;
            timer_enable   <= 1'b0;
            timer_reset    <= 1'b0;
            move_grant     <= 1'b0;
            auto_req       <= 1'b0;
            current_player <= 1'b0;
            turn_count     <= '0;
            game_over      <= 1'b0;
            winner         <= WIN_NONE;
        end else begin
            timer_reset <= 1'b0;
            move_grant  <= 1'b0;
            case (state)
                ST_IDLE, ST_OVER: begin
                    if (start) begin
                        state          <= ST_ARM;
                        timer_reset    <= 1'b1;
                        timer_enable   <= 1'b0;
                        game_over      <= 1'b0;
                        winner         <= WIN_NONE;
                        current_player <= 1'b0;
                        turn_count     <= '0;
                    end
                end
                ST_ARM: begin
                    state        <= ST_TURN;
                    timer_enable <= 1'b1;
                end
                ST_TURN: begin
                    if (move_req) begin
                        state        <= ST_GRANT;
                        move_grant   <= 1'b1;
                        timer_enable <= 1'b0;
                        auto_move    <= 1'b0;
                    end else if (timer_timeout) begin
                        state        <= ST_AUTO;
                        auto_req     <= 1'b1;
                        timer_enable <= 1'b0;
                        auto_move    <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    state <= ST_WAIT_M;
                end
                ST_WAIT_M, ST_AUTO: begin
                    if (board_done) begin
                        state    <= ST_CHECK;
                        auto_req <= 1'b0;
                        res_ok   <= board_ok;
                        res_win  <= board_win;
                    end
                end
                ST_CHECK: begin
                    if (!res_ok) begin
                        // A rejected manual move resumes the running timer; a
                        // rejected automatic move is simply retried.
                        if (auto_move) begin
                            state    <= ST_AUTO;
                            auto_req <= 1'b1;
                        end else begin
                            state        <= ST_TURN;
                            timer_enable <= 1'b1;
                        end
                    end else begin
                        turn_count <= turn_count + 1'b1;
                        if (res_win) begin
                            state     <= ST_OVER;
                            game_over <= 1'b1;
                            winner    <= current_player ? WIN_P1 : WIN_P0;
                        end else if (turn_count == LAST_COUNT) begin
                            state     <= ST_OVER;
                            game_over <= 1'b1;
                            winner    <= WIN_DRAW;
                        end else begin
                            state          <= ST_ARM;
                            timer_reset    <= 1'b1;
                            current_player <= ~current_player;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_turn_controller.sv
// Bench for turn_controller: a table-driven game sequence, hand-written corner
// cases and randomized games checked against a transaction-level game model.
module tb_turn_controller;

    localparam int TS = 10;
    localparam int MM = 4;
    localparam int CW = $clog2(MM + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0, move_req = 1'b0, timer_timeout = 1'b0;
    logic [3:0]    timer_seconds = 4'd0;
    logic          board_done = 1'b0, board_ok = 1'b0, board_win = 1'b0;
    logic          timer_enable, timer_reset, move_grant, auto_req, current_player;
    logic [CW-1:0] turn_count;
    logic [3:0]    seconds_left;
    logic          game_over;
    logic [1:0]    winner;

    turn_controller #(.TURN_SECONDS(TS), .MAX_MOVES(MM)) dut (
        .clk(clk), .rst(rst), .start(start), .move_req(move_req),
        .timer_timeout(timer_timeout), .timer_seconds(timer_seconds),
        .board_done(board_done), .board_ok(board_ok), .board_win(board_win),
        .timer_enable(timer_enable), .timer_reset(timer_reset), .move_grant(move_grant),
        .auto_req(auto_req), .current_player(current_player), .turn_count(turn_count),
        .seconds_left(seconds_left), .game_over(game_over), .winner(winner)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_pulses();
        start = 1'b0; move_req = 1'b0; board_done = 1'b0; board_ok = 1'b0; board_win = 1'b0;
    endtask

    task automatic apply_reset();
        clear_pulses();
        timer_timeout = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    // in = {start, move_req, timeout, done, ok, win}; o = {trst, ten, grant, auto, player}
    typedef struct {
        logic [5:0] in;
        logic [4:0] o;
        int         cnt;
        logic       ov;
        logic [1:0] w;
    } vec_t;

    function automatic vec_t v(input logic [5:0] in, input logic [4:0] o, input int cnt,
                               input logic ov, input logic [1:0] w);
        vec_t r;
        r.in = in; r.o = o; r.cnt = cnt; r.ov = ov; r.w = w;
        return r;
    endfunction

    typedef struct {
        logic [3:0] secs;
        logic [3:0] left;
    } sec_vec_t;

    vec_t     tbl[32];
    sec_vec_t stbl[7];

    // Manual move from TURN: grant checks, board answer, ends one cycle after CHECK.
    task automatic play_manual(input logic ok, input logic win, input string tag);
        move_req = 1'b1;
        tick();
        move_req = 1'b0;
        check({tag, "_grant"}, move_grant, 1);
        tick();
        check({tag, "_grant_drop"}, move_grant, 0);
        board_done = 1'b1; board_ok = ok; board_win = win;
        tick();
        clear_pulses();
        tick();
    endtask

    logic [10:0] act_pk, exp_pk;
    logic        m_player, m_over, ok, win, is_auto, resolved;
    int          m_count, kind;
    logic [1:0]  m_winner;

    initial begin
        tbl[0]  = v(6'b100000, 5'b10000, 0, 0, 2'd0);
        tbl[1]  = v(6'b000000, 5'b01000, 0, 0, 2'd0);
        tbl[2]  = v(6'b000110, 5'b01000, 0, 0, 2'd0);
        tbl[3]  = v(6'b100000, 5'b01000, 0, 0, 2'd0);
        tbl[4]  = v(6'b000000, 5'b01000, 0, 0, 2'd0);
        tbl[5]  = v(6'b010000, 5'b00100, 0, 0, 2'd0);
        tbl[6]  = v(6'b000000, 5'b00000, 0, 0, 2'd0);
        tbl[7]  = v(6'b000110, 5'b00000, 0, 0, 2'd0);
        tbl[8]  = v(6'b000000, 5'b10001, 1, 0, 2'd0);
        tbl[9]  = v(6'b000000, 5'b01001, 1, 0, 2'd0);
        tbl[10] = v(6'b011000, 5'b00101, 1, 0, 2'd0);
        tbl[11] = v(6'b000000, 5'b00001, 1, 0, 2'd0);
        tbl[12] = v(6'b000100, 5'b00001, 1, 0, 2'd0);
        tbl[13] = v(6'b000000, 5'b01001, 1, 0, 2'd0);
        tbl[14] = v(6'b001000, 5'b00011, 1, 0, 2'd0);
        tbl[15] = v(6'b001000, 5'b00011, 1, 0, 2'd0);
        tbl[16] = v(6'b000100, 5'b00001, 1, 0, 2'd0);
        tbl[17] = v(6'b000000, 5'b00011, 1, 0, 2'd0);
        tbl[18] = v(6'b000110, 5'b00001, 1, 0, 2'd0);
        tbl[19] = v(6'b000000, 5'b10000, 2, 0, 2'd0);
        tbl[20] = v(6'b000000, 5'b01000, 2, 0, 2'd0);
        tbl[21] = v(6'b010000, 5'b00100, 2, 0, 2'd0);
        tbl[22] = v(6'b000000, 5'b00000, 2, 0, 2'd0);
        tbl[23] = v(6'b000110, 5'b00000, 2, 0, 2'd0);
        tbl[24] = v(6'b000000, 5'b10001, 3, 0, 2'd0);
        tbl[25] = v(6'b000000, 5'b01001, 3, 0, 2'd0);
        tbl[26] = v(6'b010000, 5'b00101, 3, 0, 2'd0);
        tbl[27] = v(6'b000000, 5'b00001, 3, 0, 2'd0);
        tbl[28] = v(6'b000111, 5'b00001, 3, 0, 2'd0);
        tbl[29] = v(6'b000000, 5'b00001, 4, 1, 2'd2);
        tbl[30] = v(6'b010000, 5'b00001, 4, 1, 2'd2);
        tbl[31] = v(6'b100000, 5'b10000, 0, 0, 2'd0);

        stbl[0] = '{4'd0, 4'd10};  stbl[1] = '{4'd4, 4'd6};  stbl[2] = '{4'd9, 4'd1};
        stbl[3] = '{4'd10, 4'd0};  stbl[4] = '{4'd12, 4'd0}; stbl[5] = '{4'd15, 4'd0};
        stbl[6] = '{4'd1, 4'd9};

        // Reset state
        rst = 1'b0;
        tick();
        check("reset_outputs",
              {timer_reset, timer_enable, move_grant, auto_req, current_player,
               turn_count, game_over, winner}, 0);
        check("reset_seconds_left", seconds_left, TS);
        rst = 1'b1;

        // Scripted game through the table
        for (int i = 0; i < 32; i++) begin
            {start, move_req, timer_timeout, board_done, board_ok, board_win} = tbl[i].in;
            tick();
            clear_pulses();
            act_pk = {timer_reset, timer_enable, move_grant, auto_req, current_player,
                      turn_count, game_over, winner};
            exp_pk = {tbl[i].o, CW'(tbl[i].cnt), tbl[i].ov, tbl[i].w};
            check($sformatf("table_row%0d", i), act_pk, exp_pk);
        end
        timer_timeout = 1'b0;

        // seconds_left is combinational from timer_seconds
        for (int i = 0; i < 7; i++) begin
            timer_seconds = stbl[i].secs;
            #1;
            check($sformatf("seconds_left_%0d", stbl[i].secs), seconds_left, stbl[i].left);
        end
        timer_seconds = 4'd0;

        // Draw after MAX_MOVES legal non-winning moves
        apply_reset();
        start = 1'b1; tick(); start = 1'b0; tick();
        for (int i = 0; i < MM; i++) begin
            play_manual(1'b1, 1'b0, $sformatf("draw_m%0d", i));
            if (i < MM - 1) tick();
        end
        check("draw_game_over", game_over, 1);
        check("draw_winner", winner, 2'b11);
        check("draw_count", turn_count, MM);
        check("draw_timer_off", timer_enable, 0);

        // Asynchronous reset while an automatic move is pending
        apply_reset();
        start = 1'b1; tick(); start = 1'b0; tick();
        timer_timeout = 1'b1; tick(); timer_timeout = 1'b0;
        check("auto_before_reset", auto_req, 1);
        #2 rst = 1'b0;
        #1;
        check("async_reset_outputs",
              {timer_reset, timer_enable, move_grant, auto_req, current_player,
               turn_count, game_over, winner}, 0);
        check("async_reset_seconds", seconds_left, TS);
        tick();
        rst = 1'b1;

        // Randomized games against the game-rule model
        for (int g = 0; g < 40; g++) begin
            clear_pulses();
            start = 1'b1; tick(); start = 1'b0;
            check("rnd_start_trst", {timer_reset, timer_enable}, 2'b10);
            m_player = 1'b0; m_count = 0; m_over = 1'b0; m_winner = 2'b00;
            tick();
            while (!m_over) begin
                check("rnd_turn_en", {timer_enable, timer_reset}, 2'b10);
                repeat ($urandom_range(0, 3)) tick();
                kind = $urandom_range(0, 2);
                is_auto = (kind == 1);
                move_req = (kind != 1);
                timer_timeout = (kind != 0);
                tick();
                move_req = 1'b0; timer_timeout = 1'b0;
                check("rnd_arbitrate", {move_grant, auto_req}, is_auto ? 2'b01 : 2'b10);
                if (!is_auto) tick();
                resolved = 1'b0;
                while (!resolved) begin
                    repeat ($urandom_range(0, 3)) begin
                        tick();
                        if (is_auto) check("rnd_auto_hold", auto_req, 1);
                    end
                    ok  = ($urandom_range(0, 3) != 0);
                    win = ok && ($urandom_range(0, 5) == 0);
                    board_done = 1'b1; board_ok = ok; board_win = win;
                    tick();
                    clear_pulses();
                    check("rnd_check_quiet", {move_grant, auto_req, timer_reset}, 0);
                    tick();
                    if (!ok) begin
                        if (is_auto) begin
                            check("rnd_auto_retry", auto_req, 1);
                        end else begin
                            resolved = 1'b1;
                        end
                    end else begin
                        resolved = 1'b1;
                        m_count++;
                        if (win) begin
                            m_over = 1'b1;
                            m_winner = m_player ? 2'b10 : 2'b01;
                        end else if (m_count == MM) begin
                            m_over = 1'b1;
                            m_winner = 2'b11;
                        end else begin
                            m_player = ~m_player;
                            check("rnd_next_trst", {timer_reset, timer_enable}, 2'b10);
                            tick();
                        end
                    end
                end
                check("rnd_state",
                      {current_player, 3'b000, CW'(m_count), game_over, winner},
                      {m_player, 3'b000, CW'(m_count), m_over, m_winner});
            end
            check("rnd_over_idle_timer", {timer_enable, timer_reset}, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
